// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel, W-bit stream multiplexer with a one-entry registered output stage.
//
// Each input channel has its own valid/ready handshake. At most one channel is granted per cycle.
// The grant comes from one of two sources:
//   - mode=0: the manual select S. An out-of-range S gives no grant.
//   - mode=1: a round-robin search that starts at ptr and wraps around.
// The accepted word appears on out_data one cycle after the accept. The output register can be
// reloaded in the same cycle it is drained, so back-to-back transfers leave no bubble.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mode       0 = manual select via S, 1 = round-robin
//   S          manual channel select (mode=0 only)
//   in_valid   per-channel valid, bit k = channel k
//   in_data    packed channel data, channel k at [k*W +: W]
//   in_ready   per-channel accept, one-hot or all-zero
//   out_valid  output register holds a valid word
//   out_data   registered output word
//   out_sel    channel ID that produced out_data
//   out_ready  downstream accepts out_data this cycle

module rr_stream_mux #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  S,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    // One extra bit so that channel indices can be compared against N and summed without overflow.
    localparam int unsigned   IW   = SW + 1;
    localparam logic [IW-1:0] NIdx = IW'(N);

    // State
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_sel_q,   out_sel_d;
    logic [SW-1:0] ptr_q,       ptr_d;

    // Combinational helpers
    logic          load_en;
    logic          grant_vld;
    logic [SW-1:0] grant;
    logic [IW-1:0] cand;
    logic [W-1:0]  sel_data;
    logic          xfer;
    logic [IW-1:0] ptr_inc;

    // The output register may take a new word when it is empty or is being drained this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Grant selection.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        if (!mode) begin
            // A manual select beyond the last channel exists only for non-power-of-two N.
            if ({1'b0, S} < NIdx) begin
                grant_vld = 1'b1;
                grant     = S;
            end
        end else begin
            // Search ptr, ptr+1, ..., wrapping at N. The first hit wins.
            // ptr_q < N and i < N, so the sum is below 2N and a single subtract wraps it.
            for (int unsigned i = 0; i < N; i++) begin
                cand = {1'b0, ptr_q} + IW'(i);
                if (cand >= NIdx) begin
                    cand = cand - NIdx;
                end
                if (!grant_vld && in_valid[cand[SW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant     = cand[SW-1:0];
                end
            end
        end
    end

    // Ready goes only to the granted channel and does not depend on that channel's valid.
    always_comb begin
        in_ready = '0;
        if (grant_vld && load_en) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = grant_vld && load_en && in_valid[grant];

    // Data path mux for the granted channel.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant == SW'(k)) begin
                sel_data = in_data[k*W +: W];
            end
        end
    end

    // Next state of the output stage and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        ptr_inc     = {1'b0, grant} + IW'(1);

        if (load_en) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_sel_d   = grant;
                // The pointer moves past the winner only in round-robin mode.
                if (mode) begin
                    ptr_d = (ptr_inc >= NIdx) ? '0 : ptr_inc[SW-1:0];
                end
            end else begin
                // Drained with nothing to replace it: data and sel keep their last values.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer; successor to the combinational 4:1 mux.
- Adds valid/ready handshaking per channel, a one-entry registered output stage, and two selection modes: manual select (S) and round-robin arbitration.
- Used in the datapath wherever several producers share one consumer, e.g. register-file write-back or bus sources.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel in bits.
- SW, $clog2(N), select/channel-ID width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = manual select via S; 1 = round-robin.
- S  input  SW  manual channel select, used only when mode=0.
- in_valid  input  N  per-channel data valid; bit k belongs to channel k.
- in_data  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
- in_ready  output  N  per-channel accept; one-hot or all-zero.
- out_valid  output  1  output register holds a valid word.
- out_data  output  W  registered output word.
- out_sel  output  SW  ID of the channel that produced out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset, sampled on a clk edge while rst=1:
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - Any held word is discarded.
  - Reset overrides every other event in the same cycle.
- Load enable: load_en = !out_valid || out_ready. A held word may be replaced in the same cycle it is consumed, so there is no bubble.
- Grant selection (combinational):
  - mode=0: g = S. If S >= N (non-power-of-two N), there is no grant and in_ready is all zero.
  - mode=1: g = first k with in_valid[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around). No valid channel means no grant.
- in_ready[g] = load_en when a grant exists; all other bits are 0. in_ready does not depend on in_valid[g] in mode 0.
- Transfer occurs when in_valid[g] && in_ready[g]. On the next edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1. Latency is 1 cycle from accept to out_valid.
- If load_en=1 and there is no transfer: out_valid <= 0. out_data and out_sel hold their last values.
- If load_en=0 (out_valid=1, out_ready=0): out_valid, out_data and out_sel are held stable, and no input is accepted.
- ptr update:
  - Only on a transfer in mode=1: ptr <= (g+1) mod N, wrapping from N-1 to 0.
  - ptr is unchanged in mode=0 and on stalls.
- Mode change takes effect combinationally in the same cycle and does not disturb a held output word. ptr is retained across mode switches.
- Only one channel is accepted per cycle, so in_ready is never multi-hot.
- A channel with in_valid=1 in mode=1 is granted within N transfers (starvation-free).

Test Plan:
- Data values: all directed scenarios use N=4, W=8, in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA}.
- Manual mode: mode=0, all in_valid=1, out_ready=1, S stepped 0,1,2,3 every 10 ns -> one cycle after each step, out_data = AA, BB, CC, DD with out_sel = 0..3. in_ready is one-hot equal to S.
- Round-robin, all valid: mode=1, in_valid=4'b1111, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles; out_valid stays 1 with no bubble.
- Sparse requests: mode=1, in_valid=4'b1010 -> out_sel alternates 1,3,1,3. in_ready[0] and in_ready[2] are never asserted.
- Backpressure: with out_valid=1, hold out_ready=0 for 5 cycles -> out_data and out_sel are stable, in_ready=0, ptr unchanged. Releasing out_ready resumes at the next channel in order with no loss or duplication.
- Reset mid-stream: assert rst for one cycle while out_valid=1 in mode=1 -> next edge gives out_valid=0, out_data=0, out_sel=0. The first grant after release is channel 0.
- Boundary check with N=3 (SW=2):
  - mode=0, S=3 -> in_ready=0 and no transfer.
  - mode=1 all valid -> out_sel wraps 0,1,2,0.
